// File: rtl/score_lane_renderer.sv
// Scrolling note-lane painter: once per repaint period, walks the score from
// the playing note and issues clipped rectangle fills to the graphics processor.
module score_lane_renderer #(
  parameter int          ADDR_W        = 8,
  parameter int          LEN_W         = 16,
  parameter int          X_START       = 351,
  parameter int          X_END         = 639,
  parameter int          Y_END         = 479,
  parameter int          LEN_SHIFT     = 2,
  parameter int          ROW_BASE      = 150,
  parameter int          ROW_PITCH     = 84,
  parameter int          BAR_H         = 15,
  parameter int          REPAINT_TICKS = 1000000,
  parameter logic [11:0] BG_COLOR      = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic [ADDR_W-1:0] note_pointer,
  input  logic [LEN_W-1:0]  cur_note_length,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [LEN_W+7:0]  score_data,
  output logic [3:0]        cur_note,
  output logic [3:0]        cur_octave,
  input  logic [11:0]       bar_color,
  output logic              gp_en,
  output logic              gp_opcode,
  output logic [9:0]        gp_tl_x,
  output logic [8:0]        gp_tl_y,
  output logic [9:0]        gp_br_x,
  output logic [8:0]        gp_br_y,
  output logic [11:0]       gp_arg,
  input  logic              gp_finish,
  output logic              busy,
  output logic              frame_done
);

  localparam int SUM_W = ((LEN_W > 11) ? LEN_W : 11) + 1;
  localparam int TMR_W = (REPAINT_TICKS > 2) ? $clog2(REPAINT_TICKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(REPAINT_TICKS - 1);
  localparam logic [10:0]      X_START_W = 11'(X_START);
  localparam logic [10:0]      X_END_W   = 11'(X_END);
  localparam logic [SUM_W-1:0] X_END_S   = SUM_W'(X_END);
  localparam logic [8:0]       Y_END_W   = 9'(Y_END);
  localparam logic [8:0]       BAR_SPAN  = 9'(BAR_H - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_TICK, S_FETCH, S_PLAN, S_CLR_TOP,
    S_CLR_BOT, S_DRAW, S_NEXT, S_TAIL, S_DONE
  } state_t;

  state_t            state, next_state;
  logic [TMR_W-1:0]  timer;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  rem_len;
  logic [10:0]       x;
  logic              first;
  logic [9:0]        br_x_r;
  logic [1:0]        row_r;
  logic              rest_r;
  logic [11:0]       color_r;
  logic              issued;
  logic              issue, retire, tick;

  logic [LEN_W-1:0]  score_len, plan_len, plan_w;
  logic [SUM_W-1:0]  plan_sum;
  logic [9:0]        plan_brx;
  logic [1:0]        plan_row;
  logic              plan_rest, plan_end;
  logic [11:0]       plan_color;

  state_t            op_st;
  logic [9:0]        sel_brx;
  logic [1:0]        sel_row;
  logic              sel_rest;
  logic [11:0]       sel_color;
  logic [8:0]        sel_top, sel_bot;
  logic [8:0]        op_tl_y, op_br_y;
  logic [9:0]        op_br_x;
  logic [11:0]       op_arg;
  logic [10:0]       x_after;

  function automatic logic [8:0] row_top(input logic [1:0] r);
    return 9'(ROW_BASE + ROW_PITCH * int'(r));
  endfunction

  assign cur_note   = score_data[7:4];
  assign cur_octave = score_data[3:0];
  assign score_len  = score_data[LEN_W+7:8];
  assign gp_opcode  = 1'b0;
  assign busy       = (state != S_IDLE) && (state != S_WAIT_TICK);
  assign x_after    = {1'b0, br_x_r} + 11'd1;

  // Per-note planning: effective length, clipped right edge, row and colour
  always_comb begin
    plan_len  = first ? rem_len : score_len;
    plan_end  = (score_len == '0) && !first;
    plan_w    = plan_len >> LEN_SHIFT;
    plan_sum  = SUM_W'(x) + SUM_W'(plan_w) - SUM_W'(1);
    // A zero-width note leaves x untouched once NEXT adds one back
    if (plan_w == '0)
      plan_brx = 10'(x - 11'd1);
    else if (plan_sum > X_END_S)
      plan_brx = X_END_W[9:0];
    else
      plan_brx = plan_sum[9:0];
    plan_row  = 2'd0;
    plan_rest = 1'b0;
    case (cur_note)
      4'd1, 4'd3, 4'd5, 4'd6: plan_row = 2'd0;
      4'd2, 4'd4, 4'd7:       plan_row = 2'd1;
      4'd8, 4'd10, 4'd12:     plan_row = 2'd2;
      4'd9, 4'd11:            plan_row = 2'd3;
      default:                plan_rest = 1'b1;
    endcase
    plan_color = plan_rest ? BG_COLOR : bar_color;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and command issue/retire decisions
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    retire     = 1'b0;
    tick       = 1'b0;
    case (state)
      S_IDLE:      if (start) next_state = S_WAIT_TICK;
      S_WAIT_TICK: if (!pause && timer == TMR_LAST) begin
                     tick       = 1'b1;
                     next_state = S_FETCH;
                   end
      S_FETCH:     next_state = S_PLAN;
      S_PLAN: begin
        if (plan_end)          next_state = S_TAIL;
        else if (plan_w == '0) next_state = S_NEXT;
        else if (plan_rest)    next_state = S_DRAW;
        else                   next_state = S_CLR_TOP;
        // The first command launches straight out of PLAN when the GP is idle
        if (next_state != S_NEXT && !gp_finish &&
            !(next_state == S_TAIL && x > X_END_W))
          issue = 1'b1;
      end
      S_CLR_TOP, S_CLR_BOT, S_DRAW, S_TAIL: begin
        if (!issued) begin
          if (state == S_TAIL && x > X_END_W) next_state = S_DONE;
          else if (!gp_finish)                issue = 1'b1;
        end else if (gp_finish) begin
          retire = 1'b1;
          case (state)
            S_CLR_TOP: next_state = S_CLR_BOT;
            S_CLR_BOT: next_state = S_DRAW;
            S_DRAW:    next_state = S_NEXT;
            default:   next_state = S_DONE;
          endcase
        end
      end
      S_NEXT:  next_state = (x_after > X_END_W) ? S_DONE : S_FETCH;
      S_DONE:  next_state = S_WAIT_TICK;
      default: next_state = S_IDLE;
    endcase
  end

  // Command geometry for the op being launched (PLAN uses its live results)
  always_comb begin
    op_st     = (state == S_PLAN) ? next_state : state;
    sel_brx   = (state == S_PLAN) ? plan_brx   : br_x_r;
    sel_row   = (state == S_PLAN) ? plan_row   : row_r;
    sel_rest  = (state == S_PLAN) ? plan_rest  : rest_r;
    sel_color = (state == S_PLAN) ? plan_color : color_r;
    sel_top   = row_top(sel_row);
    sel_bot   = sel_top + BAR_SPAN;
    op_tl_y   = '0;
    op_br_y   = Y_END_W;
    op_br_x   = sel_brx;
    op_arg    = BG_COLOR;
    case (op_st)
      S_CLR_TOP: op_br_y = sel_top - 9'd1;
      S_CLR_BOT: op_tl_y = sel_bot + 9'd1;
      S_DRAW: begin
        if (!sel_rest) begin
          op_tl_y = sel_top;
          op_br_y = sel_bot;
        end
        op_arg = sel_color;
      end
      S_TAIL:  op_br_x = X_END_W[9:0];
      default: ;
    endcase
  end

  // Timer, score walk, captured note data and GP command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      ptr        <= '0;
      score_addr <= '0;
      rem_len    <= '0;
      x          <= '0;
      first      <= 1'b0;
      br_x_r     <= '0;
      row_r      <= '0;
      rest_r     <= 1'b0;
      color_r    <= '0;
      issued     <= 1'b0;
      gp_en      <= 1'b0;
      gp_tl_x    <= '0;
      gp_tl_y    <= '0;
      gp_br_x    <= '0;
      gp_br_y    <= '0;
      gp_arg     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (next_state == S_DONE);
      case (state)
        S_WAIT_TICK: begin
          if (tick) begin
            timer      <= '0;
            ptr        <= note_pointer;
            score_addr <= note_pointer;
            rem_len    <= cur_note_length;
            x          <= X_START_W;
            first      <= 1'b1;
          end else if (!pause) begin
            timer <= timer + 1'b1;
          end
        end
        S_PLAN: begin
          br_x_r  <= plan_brx;
          row_r   <= plan_row;
          rest_r  <= plan_rest;
          color_r <= plan_color;
        end
        S_NEXT: begin
          x          <= x_after;
          ptr        <= ptr + 1'b1;
          score_addr <= ptr + 1'b1;
          first      <= 1'b0;
        end
        default: ;
      endcase
      if (issue) begin
        gp_en   <= 1'b1;
        issued  <= 1'b1;
        gp_tl_x <= x[9:0];
        gp_tl_y <= op_tl_y;
        gp_br_x <= op_br_x;
        gp_br_y <= op_br_y;
        gp_arg  <= op_arg;
      end else if (retire) begin
        gp_en  <= 1'b0;
        issued <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_lane_renderer.sv
// Directed bench for score_lane_renderer: registered score ROM, colour LUT and
// a graphics processor that echoes gp_en as gp_finish three cycles later.
`timescale 1ns/1ps
module tb_score_lane_renderer;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic [ADDR_W-1:0] note_pointer = '0;
  logic [LEN_W-1:0]  cur_note_length = '0;
  logic [ADDR_W-1:0] score_addr;
  logic [LEN_W+7:0]  score_data = '0;
  logic [3:0]        cur_note, cur_octave;
  logic [11:0]       bar_color;
  logic              gp_en, gp_opcode;
  logic [9:0]        gp_tl_x, gp_br_x;
  logic [8:0]        gp_tl_y, gp_br_y;
  logic [11:0]       gp_arg;
  logic              gp_finish;
  logic              busy, frame_done;

  logic [2:0]        fin_pipe = '0;
  logic              fin_ext = 1'b0;
  logic [LEN_W+7:0]  rom [0:255];

  int n_chk  = 0;
  int n_fail = 0;

  // Recorded commands, captured when gp_en rises
  int          op_cnt = 0;
  int          fd_cnt = 0;
  logic        en_prev = 1'b0;
  logic [9:0]  r_tlx [0:63];
  logic [8:0]  r_tly [0:63];
  logic [9:0]  r_brx [0:63];
  logic [8:0]  r_bry [0:63];
  logic [11:0] r_arg [0:63];

  score_lane_renderer #(.REPAINT_TICKS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .note_pointer(note_pointer), .cur_note_length(cur_note_length),
    .score_addr(score_addr), .score_data(score_data),
    .cur_note(cur_note), .cur_octave(cur_octave), .bar_color(bar_color),
    .gp_en(gp_en), .gp_opcode(gp_opcode), .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y),
    .gp_br_x(gp_br_x), .gp_br_y(gp_br_y), .gp_arg(gp_arg),
    .gp_finish(gp_finish), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Registered score ROM
  always @(posedge clk) score_data <= rom[score_addr];

  // Colour LUT
  assign bar_color = {cur_note, cur_octave, 4'h5};

  // Graphics processor: finish follows gp_en by three cycles
  always @(posedge clk) fin_pipe <= {fin_pipe[1:0], gp_en};
  assign gp_finish = fin_pipe[2] | fin_ext;

  // Command recorder and frame_done counter
  always @(negedge clk) begin
    if (gp_en && !en_prev) begin
      if (op_cnt < 64) begin
        r_tlx[op_cnt] = gp_tl_x;
        r_tly[op_cnt] = gp_tl_y;
        r_brx[op_cnt] = gp_br_x;
        r_bry[op_cnt] = gp_br_y;
        r_arg[op_cnt] = gp_arg;
      end
      op_cnt = op_cnt + 1;
    end
    if (frame_done) fd_cnt = fd_cnt + 1;
    en_prev = gp_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_op(input int idx, input int tlx, input int tly,
                        input int brx, input int bry, input logic [11:0] arg);
    if (idx >= 64) begin
      chk($sformatf("op%0d_recorded", idx), 32'(idx), 32'd63);
    end else begin
      chk($sformatf("op%0d_tl_x", idx), 32'(r_tlx[idx]), 32'(tlx));
      chk($sformatf("op%0d_tl_y", idx), 32'(r_tly[idx]), 32'(tly));
      chk($sformatf("op%0d_br_x", idx), 32'(r_brx[idx]), 32'(brx));
      chk($sformatf("op%0d_br_y", idx), 32'(r_bry[idx]), 32'(bry));
      chk($sformatf("op%0d_arg", idx),  32'(r_arg[idx]), 32'(arg));
    end
  endtask

  task automatic wait_frame(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
  endtask

  task automatic wait_en(input logic lvl, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (gp_en === lvl) seen = 1'b1;
    end
  endtask

  initial begin
    int  base;
    int  cnt;
    bit  seen;
    bit  any_high;

    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0]  = {16'd100,  4'd1,  4'd4};   // C,  first note: remaining length used
    rom[1]  = {16'd2000, 4'd8,  4'd3};   // G,  clipped at the right edge
    rom[4]  = {16'd9999, 4'd1,  4'd5};   // C
    rom[5]  = {16'd2,    4'd3,  4'd4};   // D,  width 0
    rom[6]  = '0;                        // end of score
    rom[8]  = {16'd400,  4'd0,  4'd0};   // rest
    rom[9]  = {16'd8,    4'd13, 4'd1};   // code 13, drawn as background
    rom[10] = '0;
    rom[12] = {16'd50,   4'd11, 4'd2};   // AS, row 3

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gp_en",      32'(gp_en),      32'd0);
    chk("rst_gp_opcode",  32'(gp_opcode),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_score_addr", 32'(score_addr), 32'd0);
    chk("rst_gp_tl_x",    32'(gp_tl_x),    32'd0);
    chk("rst_gp_br_y",    32'(gp_br_y),    32'd0);
    chk("rst_gp_arg",     32'(gp_arg),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: C from pointer 0 with remaining length 40, then clipped G
    note_pointer    = 8'd0;
    cur_note_length = 16'd40;
    base = op_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_in_wait", 32'(busy), 32'd0);
    // 10 WAIT_TICK cycles, FETCH, PLAN; the first command leaves PLAN
    cnt = 0;
    while (!gp_en && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("first_gp_en_latency", 32'(cnt), 32'd12);
    chk("busy_during_op", 32'(busy), 32'd1);
    chk("gp_opcode_fill", 32'(gp_opcode), 32'd0);
    wait_frame(3000, seen);
    chk("frame1_done", 32'(seen), 32'd1);
    chk("frame1_ops", 32'(op_cnt - base), 32'd6);
    chk_op(base + 0, 351, 0,   360, 149, 12'hFFF);
    chk_op(base + 1, 351, 165, 360, 479, 12'hFFF);
    chk_op(base + 2, 351, 150, 360, 164, 12'h145);
    chk_op(base + 3, 361, 0,   639, 317, 12'hFFF);
    chk_op(base + 4, 361, 333, 639, 479, 12'hFFF);
    chk_op(base + 5, 361, 318, 639, 332, 12'h835);

    // Frame 2: 50 paused cycles in WAIT_TICK push the frame out by 50
    note_pointer = 8'd4;
    base = op_cnt;
    @(posedge clk);
    #1;
    cnt = 1;
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    pause = 1'b1;
    repeat (50) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    pause = 1'b0;
    while (!gp_en && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("paused_frame_latency", 32'(cnt), 32'd63);
    pause = 1'b1;   // raised mid-frame: the frame still completes
    wait_frame(3000, seen);
    pause = 1'b0;
    chk("frame2_done_under_pause", 32'(seen), 32'd1);
    chk("frame2_ops", 32'(op_cnt - base), 32'd4);
    chk_op(base + 0, 351, 0,   360, 149, 12'hFFF);
    chk_op(base + 1, 351, 165, 360, 479, 12'hFFF);
    chk_op(base + 2, 351, 150, 360, 164, 12'h155);
    chk_op(base + 3, 361, 0,   639, 479, 12'hFFF);

    // Frame 3: rest and code 13, tail; gp_finish held high after first op
    note_pointer = 8'd8;
    base = op_cnt;
    wait_en(1'b1, 200, seen);
    chk("frame3_first_op", 32'(seen), 32'd1);
    chk("frame_done_count_2", 32'(fd_cnt), 32'd2);
    wait_en(1'b0, 200, seen);
    chk("frame3_first_op_retired", 32'(seen), 32'd1);
    fin_ext  = 1'b1;
    any_high = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (gp_en) any_high = 1'b1;
    end
    chk("gp_en_low_while_finish_high", 32'(any_high), 32'd0);
    fin_ext = 1'b0;
    wait_en(1'b1, 20, seen);
    chk("gp_en_after_finish_drop", 32'(seen), 32'd1);
    wait_frame(3000, seen);
    chk("frame3_done", 32'(seen), 32'd1);
    chk("frame3_ops", 32'(op_cnt - base), 32'd3);
    chk_op(base + 0, 351, 0, 360, 479, 12'hFFF);
    chk_op(base + 1, 361, 0, 362, 479, 12'hFFF);
    chk_op(base + 2, 363, 0, 639, 479, 12'hFFF);

    // Frame 4: width lands exactly on the right edge (row 3), no tail
    note_pointer    = 8'd12;
    cur_note_length = 16'd1156;
    base = op_cnt;
    wait_frame(3000, seen);
    chk("frame4_done", 32'(seen), 32'd1);
    chk("frame4_ops", 32'(op_cnt - base), 32'd3);
    chk_op(base + 0, 351, 0,   639, 401, 12'hFFF);
    chk_op(base + 1, 351, 417, 639, 479, 12'hFFF);
    chk_op(base + 2, 351, 402, 639, 416, 12'hB25);

    // Frame 5: asynchronous reset while the DRAW command is in flight
    note_pointer    = 8'd0;
    cur_note_length = 16'd40;
    base = op_cnt;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (gp_en && (op_cnt - base) == 3) seen = 1'b1;
    end
    chk("frame5_draw_in_flight", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_gp_en",      32'(gp_en),      32'd0);
    chk("midreset_busy",       32'(busy),       32'd0);
    chk("midreset_gp_tl_x",    32'(gp_tl_x),    32'd0);
    chk("midreset_score_addr", 32'(score_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = op_cnt;
    repeat (40) @(negedge clk);
    chk("idle_after_reset_no_ops", 32'(op_cnt - base), 32'd0);
    chk("idle_after_reset_busy",   32'(busy), 32'd0);
    chk("frame_done_total",        32'(fd_cnt), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
